// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that writes HI/LO once when an operation completes.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU use one registered multiplier (2-cycle op).
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              cancel,
  output logic              stall_req,
  output logic              hilo_en,
  output logic [DATA_W-1:0] hi_in,
  output logic [DATA_W-1:0] lo_in
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              hilo_en_q, hilo_en_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              req_div, req_signed, a_neg, b_neg, accept, div_zero;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [ACC_W-1:0]  mul_next, div_next, acc_step, prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix, res_hi, res_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [ACC_W-1:0]  fast_prod, fast_fix;
`endif

  // Request decode: op[0] clear means signed, op[1] set means divide.
  always_comb begin
    req_div    = op[1];
    req_signed = ~op[0];
    a_neg      = req_signed & opa[DATA_W-1];
    b_neg      = req_signed & opb[DATA_W-1];
    abs_a      = a_neg ? DATA_W'(~opa + DATA_W'(1)) : opa;
    abs_b      = b_neg ? DATA_W'(~opb + DATA_W'(1)) : opb;
    div_zero   = req_div & (opb == '0);
    accept     = (state_q == S_IDLE) & start & ~cancel;
  end

  assign stall_req = accept | (state_q == S_RUN);

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fast_prod = ACC_W'(abs_a) * ACC_W'(abs_b);
    fast_fix  = (a_neg ^ b_neg) ? ACC_W'(~fast_prod + ACC_W'(1)) : fast_prod;
  end
`endif

  // One radix-2 step: acc holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shift = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[DATA_W]) begin
      div_next = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
    acc_step = is_div_q ? div_next : mul_next;
  end

  // Sign fix-up of the final step, applied as the result is written.
  always_comb begin
    prod_fix = neg_lo_q ? ACC_W'(~acc_step + ACC_W'(1)) : acc_step;
    quo_fix  = neg_lo_q ? DATA_W'(~acc_step[DATA_W-1:0] + DATA_W'(1))
                        : acc_step[DATA_W-1:0];
    rem_fix  = neg_hi_q ? DATA_W'(~acc_step[ACC_W-1:DATA_W] + DATA_W'(1))
                        : acc_step[ACC_W-1:DATA_W];
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[ACC_W-1:DATA_W];
      res_lo = prod_fix[DATA_W-1:0];
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hilo_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = req_div;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          if (div_zero) begin
            state_d   = S_DONE;
            hilo_en_d = 1'b1;
            hi_d      = opa;
            lo_d      = '1;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!req_div) begin
            state_d   = S_DONE;
            hilo_en_d = 1'b1;
            hi_d      = fast_fix[ACC_W-1:DATA_W];
            lo_d      = fast_fix[DATA_W-1:0];
          end
`endif
          else begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(DATA_W);
            opnd_d  = req_div ? abs_b : abs_a;
            acc_d   = {{DATA_W{1'b0}}, (req_div ? abs_a : abs_b)};
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = S_DONE;
            hilo_en_d = 1'b1;
            hi_d      = res_hi;
            lo_d      = res_lo;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hilo_en_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      hilo_en_q <= hilo_en_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hilo_en = hilo_en_q;
  assign hi_in   = hi_q;
  assign lo_in   = lo_q;

endmodule
